spi_bram_loader: RTL and testbench

- Byte-stream-to-BRAM loader on port B of the MicroBlaze 32 KB local-memory BRAM block.
- Accepts bytes from the SPI receiver over a valid/ready handshake and packs them MSB-first into 32-bit words.
- Writes each word to consecutive BRAM word addresses, then optionally reads the region back and checks a modular-sum checksum.
- Lets the SPI master load program/image data while port A stays with the processor.

---
 rtl/spi_bram_loader.sv | 176 +++++++++++++++++
 tb/tb_spi_bram_loader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bram_loader.sv
// SPI byte stream to BRAM port B loader: packs bytes MSB-first into 32-bit words,
// writes them to consecutive word addresses, then optionally re-reads and checksums them.
module spi_bram_loader #(
  parameter int C_MEMSIZE     = 'h8000,
  parameter int C_PORT_AWIDTH = 32,
  parameter int C_PORT_DWIDTH = 32,
  parameter int C_NUM_WE      = 4,
  parameter int C_VERIFY      = 1
) (
  input  logic                       BRAM_Clk,
  input  logic                       BRAM_Rst,
  input  logic                       Load_Start,
  input  logic [0:C_PORT_AWIDTH-1]   Load_Base,
  input  logic [0:15]                Load_Words,
  input  logic                       Byte_Valid,
  input  logic [0:7]                 Byte_Data,
  output logic                       Byte_Ready,
  output logic                       Busy,
  output logic                       Done,
  output logic                       Error,
  output logic [0:15]                Words_Written,
  output logic                       BRAM_Rst_B,
  output logic                       BRAM_Clk_B,
  output logic                       BRAM_EN_B,
  output logic [0:C_NUM_WE-1]        BRAM_WEN_B,
  output logic [0:C_PORT_AWIDTH-1]   BRAM_Addr_B,
  output logic [0:C_PORT_DWIDTH-1]   BRAM_Dout_B,
  input  logic [0:C_PORT_DWIDTH-1]   BRAM_Din_B
);

  typedef enum logic [2:0] {IDLE, FILL, WRITE, RD_ISSUE, RD_CHECK, FINISH} state_t;

  state_t                     state;
  logic [0:C_PORT_AWIDTH-1]   base_q;
  logic [0:C_PORT_AWIDTH-1]   cur_addr;
  logic [0:15]                words_q;
  logic [0:15]                rd_cnt;
  logic                       rd_vld;
  logic [1:0]                 byte_idx;
  logic [0:C_PORT_DWIDTH-1]   word;
  logic [0:C_PORT_DWIDTH-1]   word_nxt;
  logic [C_PORT_DWIDTH-1:0]   wr_sum;
  logic [C_PORT_DWIDTH-1:0]   rd_sum;
  logic [C_PORT_DWIDTH-1:0]   rd_total;
  logic [C_PORT_AWIDTH:0]     end_addr;
  logic                       misaligned;
  logic                       out_of_range;

  assign BRAM_Rst_B = BRAM_Rst;
  assign BRAM_Clk_B = BRAM_Clk;

  // End of region computed one bit wider so a huge base+length cannot wrap into range.
  assign end_addr     = {1'b0, Load_Base} + {{(C_PORT_AWIDTH-17){1'b0}}, Load_Words, 2'b00};
  assign out_of_range = end_addr > (C_PORT_AWIDTH+1)'(C_MEMSIZE);
  assign misaligned   = |Load_Base[C_PORT_AWIDTH-2:C_PORT_AWIDTH-1];
  assign rd_total     = rd_sum + BRAM_Din_B;

  always_comb begin
    word_nxt = word;
    word_nxt[{byte_idx, 3'b000} +: 8] = Byte_Data;
  end

  always_ff @(posedge BRAM_Clk) begin
    if (BRAM_Rst) begin
      state         <= IDLE;
      Byte_Ready    <= 1'b0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      Error         <= 1'b0;
      Words_Written <= '0;
      BRAM_EN_B     <= 1'b0;
      BRAM_WEN_B    <= '0;
      BRAM_Addr_B   <= '0;
      BRAM_Dout_B   <= '0;
      base_q        <= '0;
      cur_addr      <= '0;
      words_q       <= '0;
      rd_cnt        <= '0;
      rd_vld        <= 1'b0;
      byte_idx      <= '0;
      word          <= '0;
      wr_sum        <= '0;
      rd_sum        <= '0;
    end else begin
      Done       <= 1'b0;
      BRAM_EN_B  <= 1'b0;
      BRAM_WEN_B <= '0;
      case (state)
        IDLE: if (Load_Start) begin
          Error         <= 1'b0;
          Words_Written <= '0;
          base_q        <= Load_Base;
          words_q       <= Load_Words;
          if (misaligned || out_of_range) begin
            Error <= 1'b1;
            Done  <= 1'b1;
            state <= FINISH;
          end else if (Load_Words == '0) begin
            Done  <= 1'b1;
            state <= FINISH;
          end else begin
            Busy       <= 1'b1;
            Byte_Ready <= 1'b1;
            wr_sum     <= '0;
            byte_idx   <= '0;
            cur_addr   <= Load_Base;
            state      <= FILL;
          end
        end

        FILL: if (Byte_Valid && Byte_Ready) begin
          word     <= word_nxt;
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            Byte_Ready  <= 1'b0;
            BRAM_EN_B   <= 1'b1;
            BRAM_WEN_B  <= '1;
            BRAM_Addr_B <= cur_addr;
            BRAM_Dout_B <= word_nxt;
            state       <= WRITE;
          end
        end

        WRITE: begin
          wr_sum        <= wr_sum + BRAM_Dout_B;
          Words_Written <= Words_Written + 16'd1;
          cur_addr      <= cur_addr + C_PORT_AWIDTH'(4);
          if (Words_Written + 16'd1 == words_q) begin
            if (C_VERIFY != 0) begin
              // First read is issued on the bus in the first RD_ISSUE cycle.
              BRAM_EN_B   <= 1'b1;
              BRAM_Addr_B <= base_q;
              rd_cnt      <= 16'd1;
              rd_sum      <= '0;
              rd_vld      <= 1'b0;
              state       <= RD_ISSUE;
            end else begin
              Busy  <= 1'b0;
              Done  <= 1'b1;
              state <= FINISH;
            end
          end else begin
            Byte_Ready <= 1'b1;
            state      <= FILL;
          end
        end

        RD_ISSUE: begin
          // Din reflects the read issued in the previous cycle.
          if (rd_vld) rd_sum <= rd_total;
          rd_vld <= 1'b1;
          if (rd_cnt == words_q) begin
            state <= RD_CHECK;
          end else begin
            BRAM_EN_B   <= 1'b1;
            BRAM_Addr_B <= BRAM_Addr_B + C_PORT_AWIDTH'(4);
            rd_cnt      <= rd_cnt + 16'd1;
          end
        end

        RD_CHECK: begin
          rd_sum <= rd_total;
          Error  <= (rd_total != wr_sum);
          Busy   <= 1'b0;
          Done   <= 1'b1;
          state  <= FINISH;
        end

        FINISH: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bram_loader.sv
// Directed bench for spi_bram_loader with a behavioural port-B BRAM and a bus monitor.
module tb_spi_bram_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base = '0;
  logic [15:0] words = '0;
  logic        bv = 1'b0;
  logic [7:0]  bd = '0;
  logic        br, busy, done, err;
  logic [15:0] ww;
  logic        rstb, clkb, en;
  logic [3:0]  wen;
  logic [31:0] addr, dout;
  logic [31:0] din = '0;
  logic        corrupt = 1'b0;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0, done_cnt = 0, acc_cnt = 0, rdy_bad = 0, wr_n = 0, cyc = 0;
  logic [31:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int          wr_cyc  [0:63];
  logic [31:0] mem [0:8191];

  always #5 clk = ~clk;

  spi_bram_loader dut (
    .BRAM_Clk(clk), .BRAM_Rst(rst), .Load_Start(start), .Load_Base(base),
    .Load_Words(words), .Byte_Valid(bv), .Byte_Data(bd), .Byte_Ready(br),
    .Busy(busy), .Done(done), .Error(err), .Words_Written(ww),
    .BRAM_Rst_B(rstb), .BRAM_Clk_B(clkb), .BRAM_EN_B(en), .BRAM_WEN_B(wen),
    .BRAM_Addr_B(addr), .BRAM_Dout_B(dout), .BRAM_Din_B(din)
  );

  // BRAM model: registered read, optional corruption of the word at 0x104.
  always @(posedge clk) begin
    if (en) begin
      if (wen == 4'hF) mem[addr[14:2]] <= dout;
      din <= mem[addr[14:2]] ^ ((corrupt && addr == 32'h104) ? 32'h0000_0100 : 32'h0);
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (en) en_cnt <= en_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (bv && br) acc_cnt <= acc_cnt + 1;
    if (wen != 4'h0 && br) rdy_bad <= rdy_bad + 1;
    if (en && wen == 4'hF && wr_n < 64) begin
      wr_addr[wr_n] <= addr;
      wr_data[wr_n] <= dout;
      wr_cyc[wr_n]  <= cyc;
      wr_n          <= wr_n + 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_load(input logic [31:0] b, input logic [15:0] w);
    @(negedge clk);
    base = b; words = w; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bytes(input logic [127:0] data, input int n, input int gap);
    int t;
    for (int i = 0; i < n; i++) begin
      repeat (gap) begin @(negedge clk); bv = 1'b0; end
      @(negedge clk);
      bv = 1'b1;
      bd = data[127-8*i -: 8];
      t = 0;
      while (!br && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin
        checks++; errors++;
        $display("FAIL byte_accept_timeout: byte %0d never accepted, ready=%b required 1", i, br);
      end
    end
    @(negedge clk);
    bv = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    @(negedge clk);
    while (!done && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%b required 1", done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if ({br, busy, done, err, en, wen, addr, dout, ww} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b err=%b en=%b wen=%h addr=%h dout=%h ww=%0d required all 0",
               br, busy, done, err, en, wen, addr, dout, ww);
    end
    checks++;
    if (rstb !== 1'b1) begin errors++; $display("FAIL rst_b_fwd: got %b required 1", rstb); end
    rst = 1'b0;
    idle(2);
    checks++;
    if (rstb !== 1'b0 || clkb !== clk) begin
      errors++; $display("FAIL fwd_after_reset: rst_b=%b clk_b=%b clk=%b required 0/equal", rstb, clkb, clk);
    end
  endtask

  task automatic test_basic();
    int w0, e0, d0;
    w0 = wr_n; e0 = en_cnt; d0 = done_cnt;
    start_load(32'h100, 16'd2);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b required 1", busy); end
    send_bytes(128'h0102030405060708_0000000000000000, 8, 0);
    wait_done();
    checks++;
    if (err !== 1'b0 || ww !== 16'd2) begin
      errors++; $display("FAIL basic_status: err=%b ww=%0d required 0/2", err, ww);
    end
    idle(3);
    checks++;
    if (wr_n - w0 != 2 || wr_addr[w0] !== 32'h100 || wr_data[w0] !== 32'h01020304 ||
        wr_addr[w0+1] !== 32'h104 || wr_data[w0+1] !== 32'h05060708) begin
      errors++;
      $display("FAIL basic_writes: n=%0d %h@%h %h@%h required 2 01020304@100 05060708@104",
               wr_n - w0, wr_data[w0], wr_addr[w0], wr_data[w0+1], wr_addr[w0+1]);
    end
    checks++;
    if (wr_cyc[w0+1] - wr_cyc[w0] != 5) begin
      errors++; $display("FAIL basic_throughput: got %0d cycles between writes required 5", wr_cyc[w0+1] - wr_cyc[w0]);
    end
    checks++;
    if (en_cnt - e0 != 4 || done_cnt - d0 != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_counts: en=%0d done=%0d busy=%b required 4/1/0", en_cnt - e0, done_cnt - d0, busy);
    end
  endtask

  task automatic test_toggle();
    int w0, a0, r0;
    w0 = wr_n; a0 = acc_cnt; r0 = rdy_bad;
    start_load(32'h200, 16'd2);
    send_bytes(128'hA1A2A3A4A5A6A7A8_0000000000000000, 8, 1);
    wait_done();
    idle(3);
    checks++;
    if (wr_n - w0 != 2 || wr_addr[w0] !== 32'h200 || wr_data[w0] !== 32'hA1A2A3A4 ||
        wr_addr[w0+1] !== 32'h204 || wr_data[w0+1] !== 32'hA5A6A7A8) begin
      errors++;
      $display("FAIL toggle_writes: n=%0d %h@%h %h@%h required 2 A1A2A3A4@200 A5A6A7A8@204",
               wr_n - w0, wr_data[w0], wr_addr[w0], wr_data[w0+1], wr_addr[w0+1]);
    end
    checks++;
    if (acc_cnt - a0 != 8 || rdy_bad != r0 || err !== 1'b0) begin
      errors++; $display("FAIL toggle_handshake: accepted=%0d ready_in_write=%0d err=%b required 8/0/0",
                         acc_cnt - a0, rdy_bad - r0, err);
    end
  endtask

  task automatic test_corrupt();
    corrupt = 1'b1;
    start_load(32'h100, 16'd2);
    send_bytes(128'h1112131415161718_0000000000000000, 8, 0);
    wait_done();
    checks++;
    if (err !== 1'b1 || ww !== 16'd2) begin
      errors++; $display("FAIL corrupt_error: err=%b ww=%0d required 1/2", err, ww);
    end
    corrupt = 1'b0;
    idle(6);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL corrupt_sticky: err=%b required 1", err); end
  endtask

  task automatic test_zero_words();
    int e0;
    e0 = en_cnt;
    start_load(32'h40, 16'd0);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_done: done=%b err=%b busy=%b required 1/0/0", done, err, busy);
    end
    idle(3);
    checks++;
    if (en_cnt != e0 || done !== 1'b0) begin
      errors++; $display("FAIL zero_no_access: en=%0d done=%b required 0/0", en_cnt - e0, done);
    end
  endtask

  task automatic test_reject();
    int e0, w0;
    e0 = en_cnt;
    start_load(32'h7FFC, 16'd2);
    checks++;
    if (done !== 1'b1 || err !== 1'b1) begin
      errors++; $display("FAIL reject_range: done=%b err=%b required 1/1", done, err);
    end
    idle(2);
    start_load(32'h102, 16'd1);
    checks++;
    if (done !== 1'b1 || err !== 1'b1) begin
      errors++; $display("FAIL reject_align: done=%b err=%b required 1/1", done, err);
    end
    idle(2);
    checks++;
    if (en_cnt != e0 || busy !== 1'b0) begin
      errors++; $display("FAIL reject_no_access: en=%0d busy=%b required 0/0", en_cnt - e0, busy);
    end
    // Region ending exactly at the top of memory is legal.
    w0 = wr_n;
    start_load(32'h7FF8, 16'd2);
    send_bytes(128'hCAFEF00D12345678_0000000000000000, 8, 0);
    wait_done();
    idle(2);
    checks++;
    if (err !== 1'b0 || wr_n - w0 != 2 || wr_addr[w0] !== 32'h7FF8 || wr_data[w0] !== 32'hCAFEF00D ||
        wr_addr[w0+1] !== 32'h7FFC || wr_data[w0+1] !== 32'h12345678) begin
      errors++;
      $display("FAIL top_boundary: err=%b n=%0d %h@%h %h@%h required 0 2 CAFEF00D@7FF8 12345678@7FFC",
               err, wr_n - w0, wr_data[w0], wr_addr[w0], wr_data[w0+1], wr_addr[w0+1]);
    end
  endtask

  task automatic test_midreset();
    int e0, d0, w0;
    start_load(32'h300, 16'd4);
    send_bytes(128'h212223242526_00000000000000000000, 6, 0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({br, busy, done, err, en, wen, addr, dout, ww} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: rdy=%b busy=%b done=%b err=%b en=%b wen=%h addr=%h dout=%h ww=%0d required all 0",
               br, busy, done, err, en, wen, addr, dout, ww);
    end
    rst = 1'b0;
    @(negedge clk);
    e0 = en_cnt; d0 = done_cnt;
    idle(20);
    checks++;
    if (en_cnt != e0 || done_cnt != d0) begin
      errors++; $display("FAIL midreset_quiet: en=%0d done=%0d required 0/0", en_cnt - e0, done_cnt - d0);
    end
    w0 = wr_n;
    start_load(32'h400, 16'd1);
    send_bytes(128'hDEADBEEF_000000000000000000000000, 4, 0);
    wait_done();
    idle(2);
    checks++;
    if (err !== 1'b0 || ww !== 16'd1 || wr_n - w0 != 1 || wr_addr[w0] !== 32'h400 || wr_data[w0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL midreset_reload: err=%b ww=%0d n=%0d %h@%h required 0/1/1 DEADBEEF@400",
                         err, ww, wr_n - w0, wr_data[w0], wr_addr[w0]);
    end
  endtask

  task automatic test_busy_start();
    int w0, d0;
    w0 = wr_n; d0 = done_cnt;
    start_load(32'h500, 16'd1);
    @(negedge clk);
    base = 32'h102; words = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_bytes(128'h0A0B0C0D_000000000000000000000000, 4, 0);
    wait_done();
    idle(3);
    checks++;
    if (err !== 1'b0 || ww !== 16'd1 || done_cnt - d0 != 1 || wr_n - w0 != 1 ||
        wr_addr[w0] !== 32'h500 || wr_data[w0] !== 32'h0A0B0C0D) begin
      errors++; $display("FAIL busy_start_ignored: err=%b ww=%0d done=%0d n=%0d %h@%h required 0/1/1/1 0A0B0C0D@500",
                         err, ww, done_cnt - d0, wr_n - w0, wr_data[w0], wr_addr[w0]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_corrupt();
    test_zero_words();
    test_reject();
    test_midreset();
    test_busy_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
